// File: rtl/usb_pkg.sv
// Shared USB device definitions: endpoint buffer sizing and the byte type.
package usb_pkg;

  localparam int unsigned BUFFER_DEPTH = 64;
  localparam int unsigned BUFFER_OCC_W = $clog2(BUFFER_DEPTH) + 1;

  typedef logic [7:0] byte_t;

endpackage : usb_pkg

// File: rtl/data_buffer_mem.sv
// Endpoint byte storage: one synchronous write port, one asynchronous read port.
module data_buffer_mem
  import usb_pkg::*;
#(
  parameter int unsigned DEPTH = BUFFER_DEPTH,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  byte_t         wdata,
  input  logic [AW-1:0] raddr,
  output byte_t         rdata
);

  byte_t mem_q [DEPTH];

  // Contents are intentionally not reset; occupancy decides what is valid.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule : data_buffer_mem

// File: rtl/data_buffer.sv
// Shared 64-byte endpoint FIFO between usb_rx/usb_tx and the AHB-lite slave.
// Define DATA_BUFFER_ERROR_EN to build the sticky overflow/underflow flag.
module data_buffer
  import usb_pkg::*;
#(
  parameter  int unsigned DEPTH = BUFFER_DEPTH,
  localparam int unsigned OCC_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             store_rx_packet_data,
  input  byte_t            rx_packet_data,
  input  logic             flush,
  input  logic             clear,
  input  logic             store_tx_data,
  input  byte_t            tx_data,
  input  logic             get_rx_data,
  input  logic             get_tx_packet_data,
  output byte_t            rx_data,
  output byte_t            tx_packet_data,
  output logic [OCC_W-1:0] buffer_occupancy,
  output logic             buffer_error
);

  localparam int unsigned PTR_W = OCC_W - 1;

  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;

  logic  push_req, pop_req, empty, full, push_ok, pop_ok, wipe, mem_we;
  byte_t wdata, head;

  always_comb begin
    push_req = store_rx_packet_data | store_tx_data;
    pop_req  = get_rx_data | get_tx_packet_data;
    wdata    = store_rx_packet_data ? rx_packet_data : tx_data;
    empty    = (occ_q == '0);
    full     = (occ_q == OCC_W'(DEPTH));
    wipe     = flush | clear;
    // When full, a concurrent pop frees the slot the push lands in.
    push_ok  = push_req & (~full | pop_req);
    pop_ok   = pop_req & ~empty;
    mem_we   = push_ok & ~wipe;

    wptr_d = wptr_q;
    rptr_d = rptr_q;
    occ_d  = occ_q;
    if (wipe) begin
      wptr_d = '0;
      rptr_d = '0;
      occ_d  = '0;
    end else begin
      if (push_ok) wptr_d = wptr_q + PTR_W'(1);
      if (pop_ok)  rptr_d = rptr_q + PTR_W'(1);
      occ_d = occ_q + OCC_W'(push_ok) - OCC_W'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      occ_q  <= occ_d;
    end
  end

  data_buffer_mem #(
    .DEPTH (DEPTH),
    .AW    (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wptr_q),
    .wdata (wdata),
    .raddr (rptr_q),
    .rdata (head)
  );

  assign rx_data          = empty ? 8'h00 : head;
  assign tx_packet_data   = empty ? 8'h00 : head;
  assign buffer_occupancy = occ_q;

`ifdef DATA_BUFFER_ERROR_EN
  logic err_q, err_d, err_event;

  // Sticky on source collision, overflow or underflow; wiped with the contents.
  always_comb begin
    err_event = (store_rx_packet_data & store_tx_data)
              | (push_req & full & ~pop_req)
              | (pop_req & empty);
    err_d = err_q | err_event;
    if (wipe) err_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!n_rst) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign buffer_error = err_q;
`else
  assign buffer_error = 1'b0;
`endif

endmodule : data_buffer

// File: tb/tb_data_buffer.sv
// Scoreboard bench for data_buffer: queue-based reference model, directed + random traffic.
module tb_data_buffer;
  import usb_pkg::*;

  localparam int DEPTH = 64;
`ifdef DATA_BUFFER_ERROR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       store_rx_packet_data = 1'b0, store_tx_data = 1'b0;
  byte_t      rx_packet_data = 8'h00, tx_data = 8'h00;
  logic       flush = 1'b0, clear = 1'b0;
  logic       get_rx_data = 1'b0, get_tx_packet_data = 1'b0;
  byte_t      rx_data, tx_packet_data;
  logic [6:0] buffer_occupancy;
  logic       buffer_error;

  int checks = 0;
  int passes = 0;

  byte_t model_q[$];
  bit    model_err = 1'b0;
  byte_t exp_q[$];

  always #5 clk = ~clk;

  data_buffer dut (
    .clk                  (clk),
    .n_rst                (n_rst),
    .store_rx_packet_data (store_rx_packet_data),
    .rx_packet_data       (rx_packet_data),
    .flush                (flush),
    .clear                (clear),
    .store_tx_data        (store_tx_data),
    .tx_data              (tx_data),
    .get_rx_data          (get_rx_data),
    .get_tx_packet_data   (get_tx_packet_data),
    .rx_data              (rx_data),
    .tx_packet_data       (tx_packet_data),
    .buffer_occupancy     (buffer_occupancy),
    .buffer_error         (buffer_error)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Applies one cycle of strobes, advances the model, then checks post-edge state.
  task automatic step(input bit rst_n, input bit srx, input byte_t rxd, input bit stx,
                      input byte_t txd, input bit grx, input bit gtx,
                      input bit fl, input bit cl);
    byte_t h;
    n_rst = rst_n;
    store_rx_packet_data = srx; rx_packet_data = rxd;
    store_tx_data = stx; tx_data = txd;
    get_rx_data = grx; get_tx_packet_data = gtx;
    flush = fl; clear = cl;

    if (!rst_n || fl || cl) begin
      model_q.delete();
      model_err = 1'b0;
    end else begin
      if (srx && stx) model_err = 1'b1;
      if (grx || gtx) begin
        if (model_q.size() == 0) model_err = 1'b1;
        else begin
          h = model_q.pop_front();
          exp_q.push_back(h);
        end
      end
      if (srx || stx) begin
        if (model_q.size() < DEPTH) model_q.push_back(srx ? rxd : txd);
        else model_err = 1'b1;
      end
    end

    @(posedge clk);
    #1;
    chk("occupancy", 32'(buffer_occupancy), 32'(model_q.size()));
    chk("buffer_error", 32'(buffer_error), 32'(model_err & ERR_EN));
    h = (model_q.size() == 0) ? 8'h00 : model_q[0];
    chk("head_rx_data", 32'(rx_data), 32'(h));
    chk("head_tx_packet_data", 32'(tx_packet_data), 32'(h));
  endtask

  task automatic push_rx(input byte_t b); step(1, 1, b, 0, 8'h00, 0, 0, 0, 0); endtask
  task automatic push_tx(input byte_t b); step(1, 0, 8'h00, 1, b, 0, 0, 0, 0); endtask
  task automatic pop_rx();                step(1, 0, 8'h00, 0, 8'h00, 1, 0, 0, 0); endtask
  task automatic pop_tx();                step(1, 0, 8'h00, 0, 8'h00, 0, 1, 0, 0); endtask

  // Monitor: every accepted pop must present the scoreboard's next byte on both heads.
  always @(negedge clk) begin
    if (n_rst === 1'b1 && !flush && !clear && (get_rx_data || get_tx_packet_data) &&
        !$isunknown(buffer_occupancy) && buffer_occupancy != 0) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL pop_scoreboard: DUT popped %0h with no expected entry at %0t",
                 rx_data, $time);
      end else begin
        byte_t e;
        e = exp_q.pop_front();
        chk("pop_rx_data", 32'(rx_data), 32'(e));
        chk("pop_tx_packet_data", 32'(tx_packet_data), 32'(e));
      end
    end
  end

  initial begin
    @(posedge clk); #1;
    // Reset held two cycles with a push strobe active.
    step(0, 1, 8'h5A, 0, 8'h00, 0, 0, 0, 0);
    step(0, 1, 8'hA5, 0, 8'h00, 0, 0, 0, 0);

    for (int i = 0; i < 4; i++) push_rx(byte_t'(i));
    for (int i = 0; i < 4; i++) pop_rx();

    // Fill, overflow, drain (both pointers wrap from offset 4).
    for (int i = 0; i < DEPTH; i++) push_rx(byte_t'(8'h40 + i));
    push_rx(8'hEE);
    for (int i = 0; i < DEPTH; i++) begin
      if (i[0]) pop_tx(); else pop_rx();
    end
    pop_rx();

    // Full buffer with simultaneous push and pop.
    step(1, 0, 8'h00, 0, 8'h00, 0, 0, 0, 1);
    for (int i = 0; i < DEPTH; i++) push_tx(byte_t'($urandom));
    step(1, 1, 8'hAA, 0, 8'h00, 1, 0, 0, 0);
    for (int i = 0; i < DEPTH - 1; i++) pop_rx();
    chk("aa_at_head", 32'(rx_data), 32'h0000_00AA);
    pop_rx();

    // Flush with a simultaneous push, then underflow.
    for (int i = 0; i < 10; i++) push_rx(byte_t'($urandom));
    step(1, 1, 8'h77, 0, 8'h00, 0, 0, 1, 0);
    pop_rx();

    // Empty with push and pop together.
    step(1, 0, 8'h00, 0, 8'h00, 0, 0, 0, 1);
    step(1, 1, 8'h3C, 0, 8'h00, 0, 1, 0, 0);

    // RX/TX collision.
    step(1, 0, 8'h00, 0, 8'h00, 0, 0, 1, 0);
    step(1, 1, 8'h11, 1, 8'h22, 0, 0, 0, 0);
    pop_rx();
    step(1, 1, 8'h33, 0, 8'h00, 1, 1, 0, 0);

    // Randomized traffic, including occasional mid-stream reset.
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = int'($urandom_range(0, 999));
      step(r >= 5,
           $urandom_range(0, 99) < 35, byte_t'($urandom),
           $urandom_range(0, 99) < 15, byte_t'($urandom),
           $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 20,
           $urandom_range(0, 99) < 1, $urandom_range(0, 199) < 1);
    end
    step(1, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule : tb_data_buffer
